// File: rtl/conv_window_sequencer.sv
// conv_window_sequencer: walks every valid 3x3 window of an IMG_W x IMG_H
// frame in row-major order, gathers the nine pixels from a one-cycle-latency
// pixel memory, hands the window to a serial convolution engine and presents
// each engine result, tagged with its window origin, on a valid/ready output.
module conv_window_sequencer #(
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  output logic              busy,
  output logic              frame_done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic [71:0]       win_flat,
  output logic              eng_start,
  input  logic              eng_done,
  input  logic [15:0]       eng_out,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [15:0]       res_data,
  output logic [3:0]        res_row,
  output logic [3:0]        res_col
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LAST, S_FIRE, S_WAIT, S_EMIT
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [3:0]          r_row;
  logic [3:0]          r_col;
  logic [3:0]          r_idx;
  logic                r_rd_vld;
  logic [3:0]          r_rd_idx;
  logic [71:0]         r_win;
  logic [15:0]         r_res_data;
  logic [3:0]          r_res_row;
  logic [3:0]          r_res_col;
  logic                r_frame_done;
  logic                w_col_last;
  logic                w_row_last;
  logic                w_handshake;
  logic [3:0]          w_roff;
  logic [3:0]          w_coff;
  logic [ADDR_W-1:0]   w_addr;

  // Scan-position flags, window element offsets and the row-major pixel address
  always_comb begin
    w_col_last  = (r_col == 4'(IMG_W - 3));
    w_row_last  = (r_row == 4'(IMG_H - 3));
    w_handshake = (r_state == S_EMIT) && res_ready;
    w_roff      = r_idx / 4'd3;
    w_coff      = r_idx % 4'd3;
    w_addr      = (ADDR_W'(r_row) + ADDR_W'(w_roff)) * ADDR_W'(IMG_W)
                + ADDR_W'(r_col) + ADDR_W'(w_coff);
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // FSM next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (go) w_next = S_FETCH;
      S_FETCH: if (r_idx == 4'd8) w_next = S_LAST;
      S_LAST:  w_next = S_FIRE;
      S_FIRE:  w_next = S_WAIT;
      S_WAIT:  if (eng_done) w_next = S_EMIT;
      S_EMIT:  if (res_ready) w_next = (w_col_last && w_row_last) ? S_IDLE : S_FETCH;
      default: w_next = S_IDLE;
    endcase
  end

  // FSM outputs; the address bus is parked at zero whenever no read is issued
  always_comb begin
    busy       = (r_state != S_IDLE);
    mem_rd_en  = (r_state == S_FETCH);
    mem_addr   = (r_state == S_FETCH) ? w_addr : '0;
    eng_start  = (r_state == S_FIRE);
    res_valid  = (r_state == S_EMIT);
    frame_done = r_frame_done;
    win_flat   = r_win;
    res_data   = r_res_data;
    res_row    = r_res_row;
    res_col    = r_res_col;
  end

  // Scan position (row/col) and fetch index bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_row <= '0;
      r_col <= '0;
      r_idx <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (go) begin
            r_row <= '0;
            r_col <= '0;
            r_idx <= '0;
          end
        end
        S_FETCH: begin
          if (r_idx != 4'd8) r_idx <= r_idx + 4'd1;
        end
        S_EMIT: begin
          if (res_ready) begin
            r_idx <= '0;
            if (!w_col_last) begin
              r_col <= r_col + 4'd1;
            end else if (!w_row_last) begin
              r_col <= '0;
              r_row <= r_row + 4'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Read-return tracking: memory data for index k lands one cycle after its read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_vld <= 1'b0;
      r_rd_idx <= '0;
    end else begin
      r_rd_vld <= (r_state == S_FETCH);
      r_rd_idx <= r_idx;
    end
  end

  // Window assembly; only written while reads return, so it is frozen from FIRE on
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_win <= '0;
    end else if (r_rd_vld) begin
      for (int k = 0; k < 9; k++) begin
        if (r_rd_idx == 4'(k)) r_win[8*k +: 8] <= mem_rdata;
      end
    end
  end

  // Result capture on engine completion; eng_done outside WAIT is ignored
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_res_data <= '0;
      r_res_row  <= '0;
      r_res_col  <= '0;
    end else if ((r_state == S_WAIT) && eng_done) begin
      r_res_data <= eng_out;
      r_res_row  <= r_row;
      r_res_col  <= r_col;
    end
  end

  // Frame completion pulse in the first IDLE cycle after the final handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_frame_done <= 1'b0;
    else     r_frame_done <= w_handshake && w_col_last && w_row_last;
  end

endmodule

// File: doc/conv_window_sequencer.md
CONV_WINDOW_SEQUENCER -- requirements
Module: conv_window_sequencer

Interface
REQ-001 Parameter IMG_W, default 8, image width in pixels, range 3..16.
REQ-002 Parameter IMG_H, default 8, image height in pixels, range 3..16.
REQ-003 Parameter ADDR_W, default 8, pixel memory address width; shall satisfy 2**ADDR_W >= IMG_W*IMG_H.
REQ-004 clk  in  1  single clock; all state changes on the rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 go  in  1  single-cycle request to process one frame.
REQ-007 busy  out  1  high from the cycle after an accepted go until the frame completes.
REQ-008 frame_done  out  1  one-cycle pulse after the last result is accepted.
REQ-009 mem_rd_en  out  1  pixel memory read strobe.
REQ-010 mem_addr  out  ADDR_W  pixel address, row-major (row*IMG_W+col).
REQ-011 mem_rdata  in  8  pixel data, valid exactly one cycle after mem_rd_en.
REQ-012 win_flat  out  72  window to engine; byte i = window element i (i=r*3+c, byte 0 = top-left), maps to engine in0..in8.
REQ-013 eng_start  out  1  one-cycle start pulse to the serial conv engine.
REQ-014 eng_done  in  1  engine completion flag.
REQ-015 eng_out  in  16  engine result, valid while eng_done is high.
REQ-016 res_valid  out  1  result available.
REQ-017 res_ready  in  1  downstream accepts the result.
REQ-018 res_data  out  16  captured convolution result.
REQ-019 res_row, res_col  out  4 each  top-left coordinate of the window producing res_data.

Function
REQ-020 The FSM shall have states IDLE, FETCH, LAST, FIRE, WAIT, EMIT; valid-convolution scan over (IMG_H-2) x (IMG_W-2) positions, row-major, col inner.
REQ-021 IDLE: go=1 shall clear row/col to 0 and fetch index to 0, then enter FETCH; busy=0 in IDLE only.
REQ-022 FETCH: each cycle mem_rd_en=1, mem_addr=(row+idx/3)*IMG_W+col+idx%3 for idx 0..8; 9 cycles, then LAST.
REQ-023 Read data for index k shall be written to win_flat byte k on the cycle after its read; LAST captures byte 8 with mem_rd_en=0.
REQ-024 FIRE: eng_start=1 for exactly one cycle, win_flat stable and complete; next state WAIT.
REQ-025 win_flat shall hold unchanged from FIRE until the next FETCH begins.
REQ-026 WAIT: on eng_done=1, res_data<=eng_out, res_row<=row, res_col<=col, enter EMIT; eng_done outside WAIT is ignored.
REQ-027 EMIT: res_valid=1; res_data/res_row/res_col stable while res_ready=0.
REQ-028 EMIT with res_ready=1: if col<IMG_W-3, col+1 and FETCH; else if row<IMG_H-3, col=0, row+1 and FETCH; else frame_done=1 for that next cycle and IDLE.
REQ-029 frame_done shall assert in the first IDLE cycle after the final handshake, never coincident with res_valid.
REQ-030 go while busy=1 shall be ignored; go in the frame_done cycle shall be accepted.
REQ-031 Per-window latency from FETCH entry to res_valid shall be 11 cycles plus engine cycles (FIRE to eng_done).
REQ-032 Address arithmetic shall not wrap: max address IMG_W*IMG_H-1.

Reset
REQ-033 rst=1 shall immediately force IDLE and zero busy, frame_done, mem_rd_en, mem_addr, win_flat, eng_start, res_valid, res_data, res_row, res_col, row, col, idx.
REQ-034 Reset in any state (including WAIT mid-engine-run) shall abandon the frame; a later eng_done shall be ignored; next go starts at (0,0).

Verification
REQ-035 IMG_W=IMG_H=4, all pixels 1, engine kernel all 1, go pulse -> 4 results of 9 at (0,0),(0,1),(1,0),(1,1), then one frame_done.
REQ-036 IMG_W=IMG_H=4, pixel=address, kernel all 1 -> results 45, 54, 81, 90 in scan order.
REQ-037 res_ready held 0 for 5 cycles in EMIT -> res_valid stays 1, res_data unchanged, no new mem_rd_en or eng_start.
REQ-038 go pulsed during WAIT -> ignored; result count and frame_done count unchanged.
REQ-039 rst asserted mid-WAIT of window 2, later eng_done=1 -> all outputs 0, FSM stays IDLE; subsequent go -> first result at (0,0).
REQ-040 Timing check: eng_start exactly 10 cycles after first mem_rd_en of a window; mem_addr sequence for window (1,1), IMG_W=4 -> 5,6,7,9,10,11,13,14,15.
